// File: rtl/alu_sched_pkg.sv
// Shared ALU opcode/width defines and the scheduler's package: FSM state type
// and the set of opcodes that need a multi-cycle operand hold.
`ifndef ALU_DEFINES_SV
`define ALU_DEFINES_SV
`define DATA_BITS 8
`define ADD  0
`define SUB  1
`define MULT 2
`define DIV  3
`define INC  4
`define DEC  5
`define AND  6
`define OR   7
`define XOR  8
`endif

package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

    localparam int unsigned MULTI_CYCLE_OPS [2] = '{`MULT, `DIV};

    function automatic logic is_multi_cycle(input int unsigned op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (op == MULTI_CYCLE_OPS[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ALU.sv
// Shared combinational ALU. Binary ops take data_B as the left operand
// (SUB = B - A, DIV = B / A); INC/DEC act on data_B only.
module ALU #(
    parameter int DATA_W = `DATA_BITS
) (
    input  logic [DATA_W-1:0] op,
    input  logic [DATA_W-1:0] data_A,
    input  logic [DATA_W-1:0] data_B,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = data_B;
        case (op)
            DATA_W'(`ADD):  result = data_A + data_B;
            DATA_W'(`SUB):  result = data_B - data_A;
            DATA_W'(`MULT): result = data_A * data_B;
            // A zero divisor yields 0 here; the scheduler flags it separately.
            DATA_W'(`DIV):  result = (data_A == '0) ? '0 : data_B / data_A;
            DATA_W'(`INC):  result = data_B + DATA_W'(1);
            DATA_W'(`DEC):  result = data_B - DATA_W'(1);
            DATA_W'(`AND):  result = data_A & data_B;
            DATA_W'(`OR):   result = data_A | data_B;
            DATA_W'(`XOR):  result = data_A ^ data_B;
            default:        result = data_B;
        endcase
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = req;
        if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
    end

    // Resetting to 1 hands the first tie to requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Front-end for the shared ALU: arbitrates two requesters, holds operands for the
// op's settle time, and returns the captured result through a response port.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int DATA_W     = `DATA_BITS,
    parameter int MULDIV_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_result,
    output logic              resp_div0,
    output logic              busy
);

    localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    sched_state_t      state_reg;
    logic [DATA_W-1:0] op_reg, a_reg, b_reg;
    logic              id_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [1:0]        grant;
    logic              accept;
    logic              div0;
    logic [DATA_W-1:0] sel_op, sel_a, sel_b;
    logic [DATA_W-1:0] alu_result;

    assign accept     = (state_reg == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = rst_n && (state_reg == IDLE) && grant[0];
    assign req1_ready = rst_n && (state_reg == IDLE) && grant[1];

    assign sel_op = grant[1] ? req1_op : req0_op;
    assign sel_a  = grant[1] ? req1_a  : req0_a;
    assign sel_b  = grant[1] ? req1_b  : req0_b;
    assign div0   = (op_reg == DATA_W'(`DIV)) && (a_reg == '0);

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    ALU #(.DATA_W(DATA_W)) u_alu (
        .op     (op_reg),
        .data_A (a_reg),
        .data_B (b_reg),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            id_reg      <= 1'b0;
            cnt_reg     <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_div0   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= sel_op;
                        a_reg     <= sel_a;
                        b_reg     <= sel_b;
                        id_reg    <= grant[1];
                        cnt_reg   <= is_multi_cycle(32'(sel_op)) ? CNT_W'(MULDIV_LAT - 1) : '0;
                        busy      <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        resp_result <= div0 ? '0 : alu_result;
                        resp_div0   <= div0;
                        resp_id     <= id_reg;
                        resp_valid  <= 1'b1;
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomized and directed bench for alu_scheduler, checked against a
// transaction-level model (arbitration rule, latency formula, reference arithmetic).
module tb_alu_scheduler;

    localparam int W   = 8;
    localparam int LAT = 3;
    localparam int OP_ADD = 0, OP_SUB = 1, OP_MULT = 2, OP_DIV = 3, OP_INC = 4;
    localparam int OP_DEC = 5, OP_AND = 6, OP_OR = 7, OP_XOR = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
    logic         resp_valid, resp_ready, resp_id, resp_div0, busy;
    logic [W-1:0] resp_result;

    logic         pv [2];
    logic [W-1:0] pop [2];
    logic [W-1:0] pa [2];
    logic [W-1:0] pb [2];

    assign req0_valid = pv[0];
    assign req1_valid = pv[1];
    assign req0_op = pop[0];
    assign req0_a  = pa[0];
    assign req0_b  = pb[0];
    assign req1_op = pop[1];
    assign req1_a  = pa[1];
    assign req1_b  = pb[1];

    always #5 clk = ~clk;

    alu_scheduler #(.DATA_W(W), .MULDIV_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req1_valid  (req1_valid),
        .req0_ready  (req0_ready),
        .req1_ready  (req1_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_div0   (resp_div0),
        .busy        (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Transaction-level model of the scheduler.
    bit           inflight = 0;
    int           resp_cyc = 0;
    int           job_id = 0;
    logic [W-1:0] job_res = '0;
    bit           job_div0 = 0;
    int           last_win = 1;

    // Observations of the DUT used by directed checks.
    typedef struct {int id; int res; int div0;} resp_t;
    resp_t obs_q[$];
    int    obs_acc = -1;
    int    obs_lat = -1;
    int    hs_cyc  = -1;
    bit    prev_rv = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_op(input int op, input int a, input int b);
        int r;
        bit z;
        z = 0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = b - a;
            OP_MULT: r = a * b;
            OP_DIV:  if (a == 0) begin r = 0; z = 1; end else r = b / a;
            OP_INC:  r = b + 1;
            OP_DEC:  r = b - 1;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = b;
        endcase
        return {z, r[W-1:0]};
    endfunction

    // Called at posedge+1 with inputs already driven; checks this cycle, then advances one clock.
    task automatic step();
        int         win;
        int         acc_win;
        bit         exp_rv;
        logic [W:0] e;
        #2;
        win = -1;
        acc_win = -1;
        if (!inflight) begin
            if (pv[0] && pv[1]) win = (last_win == 1) ? 0 : 1;
            else if (pv[0])     win = 0;
            else if (pv[1])     win = 1;
        end
        check("req0_ready", req0_ready, win == 0);
        check("req1_ready", req1_ready, win == 1);
        check("busy", busy, inflight);
        exp_rv = inflight && (cyc >= resp_cyc);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv) begin
            check("resp_id", resp_id, job_id);
            check("resp_result", resp_result, job_res);
            check("resp_div0", resp_div0, job_div0);
        end
        if (req0_ready || req1_ready) obs_acc = cyc;
        if (resp_valid && !prev_rv) obs_lat = cyc - obs_acc;
        prev_rv = resp_valid;
        if (resp_valid && resp_ready) begin
            hs_cyc = cyc;
            obs_q.push_back('{int'(resp_id), int'(resp_result), int'(resp_div0)});
            $display("[TB] cycle %0d resp id=%0d result=0x%0h div0=%0d", cyc, resp_id, resp_result, resp_div0);
        end
        if (exp_rv && resp_ready) begin
            inflight = 0;
        end else if (win >= 0) begin
            e        = ref_op(int'(pop[win]), int'(pa[win]), int'(pb[win]));
            job_res  = e[W-1:0];
            job_div0 = e[W];
            job_id   = win;
            resp_cyc = cyc + ((pop[win] == W'(OP_MULT) || pop[win] == W'(OP_DIV)) ? 1 + LAT : 2);
            inflight = 1;
            last_win = win;
            acc_win  = win;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (acc_win >= 0) pv[acc_win] = 1'b0;
    endtask

    task automatic put_req(input int n, input int op, input int a, input int b);
        pv[n]  = 1'b1;
        pop[n] = W'(op);
        pa[n]  = W'(a);
        pb[n]  = W'(b);
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((inflight || pv[0] || pv[1]) && k < max) begin
            step();
            k++;
        end
        check("drain_within_budget", k < max, 1);
    endtask

    // Asserts reset between clock edges and checks outputs clear immediately.
    task automatic apply_reset();
        rst_n = 1'b0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_result", resp_result, 0);
        check("rst_resp_div0", resp_div0, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        inflight = 0;
        last_win = 1;
        prev_rv  = 0;
    endtask

    initial begin
        int t0, acc0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int n = 0; n < 2; n++) begin
            pop[n] = '0; pa[n] = '0; pb[n] = '0;
        end
        resp_ready = 1'b0;
        #2;
        apply_reset();

        // ADD 3+5 from reset
        resp_ready = 1'b1;
        obs_q.delete();
        t0 = cyc;
        put_req(0, OP_ADD, 3, 5);
        drain(20);
        check("t1_accept_cycle", obs_acc, t0);
        check("t1_latency", obs_lat, 2);
        check("t1_count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("t1_result", obs_q[0].res, 8);
            check("t1_id", obs_q[0].id, 0);
            check("t1_div0", obs_q[0].div0, 0);
        end

        // Simultaneous requests from reset: req0 first
        apply_reset();
        obs_q.delete();
        put_req(0, OP_SUB, 2, 9);
        put_req(1, OP_XOR, 'hF, 'h5);
        drain(30);
        check("t2_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t2_first_id", obs_q[0].id, 0);
            check("t2_first_result", obs_q[0].res, 7);
            check("t2_second_id", obs_q[1].id, 1);
            check("t2_second_result", obs_q[1].res, 'hA);
        end

        // MULT latency
        obs_q.delete();
        put_req(1, OP_MULT, 6, 7);
        drain(30);
        check("t3_latency", obs_lat, 1 + LAT);
        check("t3_count", obs_q.size(), 1);
        if (obs_q.size() == 1) begin
            check("t3_result", obs_q[0].res, 42);
            check("t3_id", obs_q[0].id, 1);
        end

        // Divide by zero, then a normal divide
        obs_q.delete();
        put_req(0, OP_DIV, 0, 10);
        drain(30);
        put_req(0, OP_DIV, 3, 10);
        drain(30);
        check("t4_count", obs_q.size(), 2);
        if (obs_q.size() == 2) begin
            check("t4_zero_result", obs_q[0].res, 0);
            check("t4_zero_div0", obs_q[0].div0, 1);
            check("t4_result", obs_q[1].res, 3);
            check("t4_div0", obs_q[1].div0, 0);
        end

        // Response back-pressure
        resp_ready = 1'b0;
        put_req(0, OP_ADD, 1, 2);
        for (int k = 0; k < 10 && !(inflight && cyc >= resp_cyc); k++) step();
        acc0 = obs_acc;
        put_req(0, OP_INC, 0, 9);
        repeat (5) step();
        check("t5_no_accept", obs_acc, acc0);
        check("t5_result_held", resp_result, 3);
        resp_ready = 1'b1;
        step();
        step();
        check("t5_bubble_accept", obs_acc, hs_cyc + 1);
        drain(20);

        // Reset during MULT execution discards the op
        put_req(1, OP_MULT, 6, 7);
        step();
        step();
        apply_reset();
        obs_q.delete();
        repeat (6) step();
        check("t6_no_response", obs_q.size(), 0);
        put_req(0, OP_DEC, 5, 0);
        drain(20);
        check("t6_dec_count", obs_q.size(), 1);
        if (obs_q.size() == 1) check("t6_dec_wrap", obs_q[0].res, 255);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pv[n] && ($urandom % 3 == 0)) begin
                    put_req(n, $urandom_range(0, 10),
                            ($urandom % 4 == 0) ? 0 : $urandom_range(0, 255),
                            ($urandom % 8 == 0) ? 0 : $urandom_range(0, 255));
                end
            end
            resp_ready = ($urandom % 4) != 0;
            step();
        end
        resp_ready = 1'b1;
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Sequencing and arbitration front-end for the shared `ALU` datapath. Two requesters submit operations through valid/ready handshakes. A round-robin arbiter grants one operation at a time. The block holds the operands stable on the ALU inputs for the op's settle time, captures the result, and returns it with the requester id through a valid/ready response port. It sits between the control/decode logic and the single combinational `ALU` instance, which it owns.

## Interface
Parameters:
- `DATA_W`, default `` `DATA_BITS ``: operand, opcode and result width.
- `MULDIV_LAT`, default 3: cycles the operands are held for `MULT`/`DIV` (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  requester has an op pending.
- `req0_ready`, `req1_ready`  out  1  op accepted this cycle (valid & ready).
- `req0_op`, `req1_op`  in  DATA_W  opcode (`` `ADD ``, `` `SUB ``, `` `MULT ``, `` `DIV ``, `` `INC ``, `` `DEC ``, `` `AND ``, `` `OR ``, `` `XOR ``; others = pass data_B).
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DATA_W  operands (data_A, data_B).
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes result.
- `resp_id`  out  1  requester that issued the op.
- `resp_result`  out  DATA_W  registered result.
- `resp_div0`  out  1  op was `DIV` with data_A == 0.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid` is high, grant one requester. The matching `reqN_ready` is high combinationally in this cycle only.
  - On the grant, latch op/a/b/id into the operand registers and load the hold counter: `MULDIV_LAT-1` for `MULT`/`DIV`, 0 otherwise. Go to EXEC.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - The `last_grant` register resets to 1, so req0 wins the first tie.
- EXEC:
  - The operand registers drive the ALU continuously.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, capture the ALU result into `resp_result`, set `resp_div0`, and go to RESP.
- Divide-by-zero: if the op is `DIV` and a == 0, capture `resp_result` = 0 and `resp_div0` = 1 instead of the ALU output.
- RESP: `resp_valid` = 1 and the outputs are held stable. On `resp_ready`, go to IDLE.
- `reqN_ready` is 0 in EXEC and RESP. A request arriving while busy waits; no request is dropped.
- Arithmetic is mod 2^DATA_W. `INC`/`DEC` ignore a, and wrap at all-ones and 0.

## Timing
- Reset values of outputs: `req*_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_result` = 0, `resp_div0` = 0, `busy` = 0. The operand registers and counter also reset to 0, and the FSM goes to IDLE.
- Latency from the accept cycle T to `resp_valid`:
  - Single-cycle ops: `resp_valid` rises at T+2.
  - `MULT`/`DIV`: `resp_valid` rises at T+1+`MULDIV_LAT`.
- Throughput: at most 1 op per 3 cycles. The RESP-to-IDLE handshake cycle and a new accept never overlap (one IDLE bubble).
- `resp_ready` held low: RESP persists indefinitely and the outputs do not change.
- Reset mid-EXEC/RESP: the in-flight op is discarded and no response is issued.
- The requester must hold `reqN_*` stable while valid and not ready. Values are sampled only on the accept edge.

## Structure
- Package `alu_sched_pkg`:
  - FSM state enum.
  - Localparam list of multi-cycle opcodes.
  - Opcodes and `DATA_BITS` stay in the shared defines file.
- Sub-module `rr_arbiter2`: 2-way round-robin with a `last_grant` register and an `advance` input pulsed on accept.
- `ALU` is instantiated once inside the block. No other module drives it.

## Test plan
- Reset, then req0 `ADD` a=3, b=5 → `req0_ready` high in cycle 0; `resp_valid` at cycle 2 with result 8, id 0, div0 0.
- req0 and req1 valid together from reset (req0 `SUB` a=2, b=9; req1 `XOR` a=0xF, b=0x5) → req0 served first (result 7), then req1 (result 0xA).
- req1 `MULT` a=6, b=7 with `MULDIV_LAT`=3 → `resp_valid` exactly 4 cycles after accept, result 42, `busy` high throughout.
- `DIV` a=0, b=10 → result 0, `resp_div0` = 1. Then `DIV` a=3, b=10 → result 3, div0 0.
- `resp_ready` held low 5 cycles with req0 valid → no new accept, result stable. Release → IDLE, then accept on the next cycle.
- `rst_n` asserted during a `MULT` EXEC → all outputs 0 immediately, no response after release. `DEC` b=0 → result all-ones.
